// File: rtl/csr_writer_if.sv
// Stream-in / word-write-out bundle for the CSR encoder.
// The encoder owns the master side: it pulls dense elements and issues memory writes.
interface csr_writer_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          wr_en;
  logic [DW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/csr_writer.sv
// Streaming dense-to-CSR encoder: writes values, column indices and row pointers
// as the matrix_base / col_base / row_base image consumed by the HHT control block.
module csr_writer #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DW     = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [DW-1:0] matrix_base,
  input  logic [DW-1:0] col_base,
  input  logic [DW-1:0] row_base,
  csr_writer_if.master  bus,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] nnz
);

  localparam int            CW       = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int            RW       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
  localparam logic [DW-1:0] ONE      = DW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PTR0,
    ACCEPT,
    WR_VAL,
    WR_COL,
    WR_PTR,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] nnz_q, nnz_d;
  logic [DW-1:0] mbase_q, mbase_d;
  logic [DW-1:0] cbase_q, cbase_d;
  logic [DW-1:0] rbase_q, rbase_d;
  logic [DW-1:0] vreg_q, vreg_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      nnz_q   <= '0;
      mbase_q <= '0;
      cbase_q <= '0;
      rbase_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      nnz_q   <= nnz_d;
      mbase_q <= mbase_d;
      cbase_q <= cbase_d;
      rbase_q <= rbase_d;
    end
  end

  // Value holding register is pure data; it is always written before it is read.
  always_ff @(posedge Clk) begin
    vreg_q <= vreg_d;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    nnz_d        = nnz_q;
    mbase_d      = mbase_q;
    cbase_d      = cbase_q;
    rbase_d      = rbase_q;
    vreg_d       = vreg_q;
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mbase_d = matrix_base;
          cbase_d = col_base;
          rbase_d = row_base;
          col_d   = '0;
          row_d   = '0;
          nnz_d   = '0;
          state_d = PTR0;
        end
      end

      PTR0: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = rbase_q;
        bus.wr_data = '0;
        state_d     = ACCEPT;
      end

      ACCEPT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_data != '0) begin
            vreg_d  = bus.in_data;
            state_d = WR_VAL;
          end else if (col_q != COL_LAST) begin
            col_d = col_q + 1'b1;
          end else begin
            state_d = WR_PTR;
          end
        end
      end

      WR_VAL: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = mbase_q + nnz_q;
        bus.wr_data = vreg_q;
        state_d     = WR_COL;
      end

      WR_COL: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = cbase_q + nnz_q;
        bus.wr_data = DW'(col_q);
        nnz_d       = nnz_q + ONE;
        if (col_q == COL_LAST) begin
          state_d = WR_PTR;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = ACCEPT;
        end
      end

      // The row pointer already counts a nonzero written in the WR_COL just before.
      WR_PTR: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = rbase_q + DW'(row_q) + ONE;
        bus.wr_data = nnz_q;
        col_d       = '0;
        if (row_q == ROW_LAST) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ACCEPT;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign nnz  = nnz_q;

endmodule

// File: tb/tb_csr_writer.sv
// Randomized bench for csr_writer with a CSR reference model feeding a write scoreboard.
module tb_csr_writer;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int DW     = 32;
  localparam int NE     = N_ROWS * N_COLS;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] matrix_base = '0;
  logic [DW-1:0] col_base = '0;
  logic [DW-1:0] row_base = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] nnz;

  csr_writer_if #(.DW(DW)) bus ();

  csr_writer #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .DW(DW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .matrix_base(matrix_base),
    .col_base   (col_base),
    .row_base   (row_base),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .nnz        (nnz)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int nz;
    int cycles;
    bit timed;
  } run_t;

  wr_t           exp_q[$];
  run_t          run_q[$];
  logic [DW-1:0] mat[NE];
  int            n_checks = 0;
  int            n_fail = 0;
  int            busy_cnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // CSR image straight from its definition: row_ptr[0]=0, (value,col) per nonzero, row_ptr[r+1]=count so far.
  task automatic push_model(input logic [DW-1:0] mb, input logic [DW-1:0] cb,
                            input logic [DW-1:0] rb, input bit timed, output int nz);
    nz = 0;
    exp_q.push_back('{rb, '0});
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (mat[r*N_COLS+c] != '0) begin
          exp_q.push_back('{mb + DW'(nz), mat[r*N_COLS+c]});
          exp_q.push_back('{cb + DW'(nz), DW'(c)});
          nz++;
        end
      end
      exp_q.push_back('{rb + DW'(r + 1), DW'(nz)});
    end
    run_q.push_back('{nz, 2 + NE + 2*nz + N_ROWS, timed});
  endtask

  // Monitor: every write is popped against the scoreboard; every done closes a run record.
  always @(negedge Clk) begin
    wr_t  e;
    run_t r;
    if (Rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write addr=%0d data=%0d expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
      end
      if (done) begin
        if (run_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          r = run_q.pop_front();
          check("final_nnz", nnz, DW'(r.nz));
          if (r.timed) check("run_cycles", DW'(busy_cnt), DW'(r.cycles));
          check("writes_outstanding", DW'(exp_q.size()), '0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic run(input logic [DW-1:0] mb, input logic [DW-1:0] cb, input logic [DW-1:0] rb,
                     input int gap_pct, input bit mid_start);
    int idx;
    int guard;
    int nz;
    bit rdy;
    bit seen;
    push_model(mb, cb, rb, (gap_pct == 0), nz);
    @(posedge Clk);
    #1;
    matrix_base = mb;
    col_base    = cb;
    row_base    = rb;
    start       = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < NE && guard < 5000) begin
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_data  = mat[idx];
      if (mid_start) start = ($urandom_range(3) == 0);
      @(negedge Clk);
      rdy = bus.in_ready;
      @(posedge Clk);
      #1;
      if (bus.in_valid && rdy) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    // Holding start through DONE: it must not relaunch the encoder.
    start = mid_start;
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 2000) begin
      @(negedge Clk);
      seen = done;
      guard++;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout actual=no_done expected=done");
    end
    @(posedge Clk);
    #1;
    start = 1'b0;
    @(negedge Clk);
    check("busy_after_done", DW'(busy), '0);
    check("nnz_hold", nnz, DW'(nz));
  endtask

  task automatic fill_random(input int zero_pct);
    for (int i = 0; i < NE; i++)
      mat[i] = ($urandom_range(99) < zero_pct) ? '0 : DW'($urandom);
  endtask

  initial begin
    int guard;
    bit seen;
    int nz;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_in_ready", DW'(bus.in_ready), '0);
    check("rst_wr_en", DW'(bus.wr_en), '0);
    check("rst_wr_addr", bus.wr_addr, '0);
    check("rst_wr_data", bus.wr_data, '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_nnz", nnz, '0);
    Rst = 1'b0;

    for (int i = 0; i < NE; i++) mat[i] = '0;
    run(32'd90, 32'd2690, 32'd28690, 0, 1'b0);

    for (int i = 0; i < NE; i++) mat[i] = ((i / N_COLS) == (i % N_COLS)) ? DW'(7) : '0;
    run(32'd0, 32'd100, 32'd200, 0, 1'b0);

    for (int i = 0; i < NE; i++) mat[i] = DW'(i + 1);
    run(32'd1000, 32'd2000, 32'd3000, 0, 1'b0);
    run(32'd1000, 32'd2000, 32'd3000, 40, 1'b1);

    for (int k = 0; k < 3; k++) begin
      fill_random(50);
      run(DW'($urandom), DW'($urandom), DW'($urandom), 0, 1'b0);
    end

    fill_random(60);
    run(32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1'b0);
    run(32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 50, 1'b1);

    // Mid-stream reset while the first value write is on the bus.
    mat[0] = DW'(5);
    exp_q.push_back('{32'd200, '0});
    exp_q.push_back('{32'd500, DW'(5)});
    @(posedge Clk);
    #1;
    matrix_base = 32'd500;
    col_base    = 32'd600;
    row_base    = 32'd200;
    start       = 1'b1;
    @(posedge Clk);
    #1;
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = mat[0];
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 50) begin
      @(negedge Clk);
      seen = bus.wr_en && (bus.wr_addr == 32'd500);
      guard++;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_val_timeout actual=no_value_write expected=value_write");
    end
    #1;
    Rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge Clk);
    check("midrst_wr_en", DW'(bus.wr_en), '0);
    check("midrst_busy", DW'(busy), '0);
    Rst = 1'b0;
    repeat (6) @(negedge Clk);
    check("midrst_pending_writes", DW'(exp_q.size()), '0);
    check("midrst_nnz", nnz, '0);

    fill_random(30);
    run(32'd40, 32'd80, 32'd120, 25, 1'b0);
    push_model(32'd7, 32'd8, 32'd9, 1'b1, nz);
    void'(exp_q.size());
    exp_q.delete();
    run_q.delete();
    fill_random(70);
    run(32'd7, 32'd8, 32'd9, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
